// File: rtl/nibble_serial_subtr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_subtr_ctrl
// Purpose  : Computes a wide A - B one nibble per clock, LSB first, through a
//            shared external 4-bit adder. Optional macro OP_ADD_EN adds an
//            'op' port that selects A + B.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_subtr_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef OP_ADD_EN
    input  logic                 op,
`endif
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 borrow,
    output logic                 zero,
    output logic [3:0]           au_a,
    output logic [3:0]           au_b,
    output logic                 au_cin,
    input  logic [3:0]           au_s,
    input  logic                 au_cout
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NIBBLES-1:0][3:0]    a_q, a_d;
    logic [NIBBLES-1:0][3:0]    b_q, b_d;
    logic [NIBBLES-1:0][3:0]    result_q, result_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       carry_q, carry_d;
    logic                       borrow_q, borrow_d;
    logic                       zero_q, zero_d;
    logic                       w_load_add;
    logic                       w_run_add;
    logic                       w_accept;

    assign w_accept = (state_q == S_IDLE) && start;

`ifdef OP_ADD_EN
    logic op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= 1'b0;
        end else if (w_accept) begin
            op_q <= op;
        end
    end

    assign w_load_add = op;
    assign w_run_add  = op_q;
`else
    assign w_load_add = 1'b0;
    assign w_run_add  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        au_a     = 4'd0;
        au_b     = 4'd0;
        au_cin   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_d      = op_a;
                    b_d      = op_b;
                    idx_d    = '0;
                    // Subtraction is A + ~B + 1, so the chain starts with carry=1
                    carry_d  = ~w_load_add;
                    result_d = '0;
                end
            end
            S_RUN: begin
                au_a            = a_q[idx_q];
                au_b            = w_run_add ? b_q[idx_q] : ~b_q[idx_q];
                au_cin          = carry_q;
                result_d[idx_q] = au_s;
                carry_d         = au_cout;
                if (idx_q == C_LAST) begin
                    state_d  = S_DONE;
                    borrow_d = w_run_add ? au_cout : ~au_cout;
                    zero_d   = (result_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_subtr_ctrl
// Purpose  : Scoreboard bench for nibble_serial_subtr_ctrl with an arithmetic
//            reference model. Exercises op port when OP_ADD_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_subtr_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, borrow, zero;
    logic [W-1:0] result;
    logic [3:0]   au_a, au_b, au_s;
    logic         au_cin, au_cout;
`ifdef OP_ADD_EN
    logic         op;
`endif

    nibble_serial_subtr_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef OP_ADD_EN
        .op      (op),
`endif
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .borrow  (borrow),
        .zero    (zero),
        .au_a    (au_a),
        .au_b    (au_b),
        .au_cin  (au_cin),
        .au_s    (au_s),
        .au_cout (au_cout)
    );

    // The shared 4-bit unit the controller sequences
    assign {au_cout, au_s} = {1'b0, au_a} + {1'b0, au_b} + {4'd0, au_cin};

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         brw;
        logic         zr;
        longint       when;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit add);
        exp_t   e;
        longint s;
        if (add) begin
            s     = longint'(a) + longint'(b);
            e.res = s[W-1:0];
            e.brw = (s >= (longint'(1) << W));
        end else begin
            s     = longint'(a) - longint'(b);
            e.res = s[W-1:0];
            e.brw = (a < b);
        end
        e.zr   = (e.res == '0);
        e.when = 0;
        return e;
    endfunction

    // Carry entering nibble i, from the low 4*i bits of the full-width sum
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input bit add, input int i);
        longint m, bb, s;
        m  = (longint'(1) << (4 * i)) - 1;
        bb = add ? longint'(b) : longint'(~b);
        s  = (longint'(a) & m) + (bb & m) + (add ? 0 : 1);
        return 1'((s >> (4 * i)) & 1);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("borrow", 64'(borrow), 64'(e.brw));
                chk("zero",   64'(zero),   64'(e.zr));
                chk("done_cycle", 64'(cyc), 64'(e.when));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit add,
                          input int intrude, input int rst_at);
        exp_t e;
        int   w;
        w = 0;
        while (busy !== 1'b0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (w >= 30) chk("idle_timeout", 64'(busy), 64'd0);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
`ifdef OP_ADD_EN
        op    = add;
`endif
        e      = model(a, b, add);
        e.when = cyc + 1 + NIBBLES;
        if (rst_at < 0) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= NIBBLES; i++) begin
            chk("busy_active", 64'(busy), 64'd1);
            if (i < NIBBLES) begin
                chk("au_a",   64'(au_a),   64'((a >> (4 * i)) & 4'hF));
                chk("au_b",   64'(au_b),   64'(((add ? b : ~b) >> (4 * i)) & 4'hF));
                chk("au_cin", 64'(au_cin), 64'(carry_into(a, b, add, i)));
            end
            if (i == intrude) begin
                start = 1'b1;
                op_a  = W'($urandom);
                op_b  = W'($urandom);
`ifdef OP_ADD_EN
                op    = 1'($urandom);
`endif
            end
            if (i == rst_at) rst_n = 1'b0;
            @(negedge clk);
            start = 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b1;
                chk("rst_busy",   64'(busy),   64'd0);
                chk("rst_done",   64'(done),   64'd0);
                chk("rst_result", 64'(result), 64'd0);
                return;
            end
        end
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_au",   64'({au_a, au_b, au_cin}), 64'd0);
        chk("hold_result", 64'(result), 64'(e.res));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
`ifdef OP_ADD_EN
        op    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({busy, done, result, borrow, zero, au_a, au_b, au_cin}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0234, 1'b0, -1, -1);
        run_op(16'h0005, 16'h0007, 1'b0, -1, -1);
        run_op(16'hABCD, 16'hABCD, 1'b0, -1, -1);
        run_op(16'h00F0, 16'h0001, 1'b0, 1, -1);
        run_op(16'h4321, 16'h1111, 1'b0, NIBBLES, -1);
        run_op(16'h9999, 16'h1111, 1'b0, -1, 1);
        run_op(16'h0010, 16'h0001, 1'b0, -1, -1);
`ifdef OP_ADD_EN
        run_op(16'hFFFF, 16'h0001, 1'b1, -1, -1);
        run_op(16'hFFFF, 16'h0001, 1'b0, -1, -1);
`endif
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] ra, rb;
            bit           radd;
            int           intr, rs;
            ra   = W'($urandom);
            rb   = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
`ifdef OP_ADD_EN
            radd = 1'($urandom);
`else
            radd = 1'b0;
`endif
            intr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NIBBLES)) : -1;
            rs   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NIBBLES - 1)) : -1;
            run_op(ra, rb, radd, intr, rs);
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
